multicycle_ctrl: RTL

//  Multicycle control FSM sitting directly upstream of the 32-bit negedge datapath registers (PC, IR, A, B, ALUout, MDR).
//  It runs on posedge clk and generates their write enables and datapath selects, so every enable is stable before the register's negedge capture.

---
 rtl/multicycle_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for a negedge-captured 32-bit datapath: drives register
// write enables and selects, handles memory wait states with timeout, counts retires.
module multicycle_ctrl #(
  parameter int OP_W    = 6,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             ir_we,
  output logic             ab_we,
  output logic             alu_we,
  output logic             mdr_we,
  output logic             rf_we,
  output logic             wb_sel,
  output logic             dst_sel,
  output logic             mem_re,
  output logic             mem_wr,
  output logic             instr_done,
  output logic             illegal_op,
  output logic             bus_err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_DEC = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b100000);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b110000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b001111);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b011111);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_B     = OP_W'(6'b111111);

  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] TO_VAL = WAIT_W'(TIMEOUT);

  state_t            state_q;
  state_t            next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              stay_wait;
  logic              timed_out;

  logic is_rtype, is_addi, is_lw, is_sw, is_beq, is_b, is_legal;

  assign is_rtype = (opcode == OP_RTYPE);
  assign is_addi  = (opcode == OP_ADDI);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_b     = (opcode == OP_B);
  assign is_legal = is_rtype | is_addi | is_lw | is_sw | is_beq | is_b;

  // Only meaningful while mem_ready is low; TIMEOUT of 0 disables the limit.
  assign timed_out = (TIMEOUT != 0) && (wait_cnt == TO_VAL);

  assign state = state_q;

  // Outputs are a pure decode so the enables settle during the high phase,
  // ahead of the datapath's negedge capture. Reset gates everything to 0.
  always_comb begin
    next_state = state_q;
    stay_wait  = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 1'b0;
    ir_we      = 1'b0;
    ab_we      = 1'b0;
    alu_we     = 1'b0;
    mdr_we     = 1'b0;
    rf_we      = 1'b0;
    wb_sel     = 1'b0;
    dst_sel    = 1'b0;
    mem_re     = 1'b0;
    mem_wr     = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    bus_err    = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IF: begin
          mem_re = 1'b1;
          if (mem_ready) begin
            ir_we      = 1'b1;
            pc_we      = 1'b1;
            next_state = S_DEC;
          end else if (timed_out) begin
            bus_err    = 1'b1;
            next_state = S_IF;
          end else begin
            stay_wait = 1'b1;
          end
        end
        S_DEC: begin
          if (is_legal) begin
            ab_we      = 1'b1;
            next_state = S_EXE;
          end else begin
            illegal_op = 1'b1;
            next_state = S_IF;
          end
        end
        S_EXE: begin
          alu_we = 1'b1;
          if (is_rtype || is_addi) begin
            next_state = S_WB;
          end else if (is_lw || is_sw) begin
            next_state = S_MEM;
          end else if (is_beq) begin
            pc_sel     = 1'b1;
            pc_we      = zero;
            instr_done = 1'b1;
            next_state = S_IF;
          end else if (is_b) begin
            pc_sel     = 1'b1;
            pc_we      = 1'b1;
            instr_done = 1'b1;
            next_state = S_IF;
          end else begin
            next_state = S_IF;
          end
        end
        S_MEM: begin
          mem_re = is_lw;
          mem_wr = is_sw;
          if (!(is_lw || is_sw)) begin
            next_state = S_IF;
          end else if (mem_ready) begin
            if (is_lw) begin
              mdr_we     = 1'b1;
              next_state = S_WB;
            end else begin
              instr_done = 1'b1;
              next_state = S_IF;
            end
          end else if (timed_out) begin
            bus_err    = 1'b1;
            next_state = S_IF;
          end else begin
            stay_wait = 1'b1;
          end
        end
        S_WB: begin
          rf_we      = 1'b1;
          wb_sel     = is_lw;
          dst_sel    = is_rtype;
          instr_done = 1'b1;
          next_state = S_IF;
        end
        default: begin
          next_state = S_IF;
        end
      endcase
    end
  end

  // Any departure from a wait (completion, timeout or state change) restarts
  // the wait counter, so it is always zero on entry to S_IF or S_MEM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IF;
      wait_cnt  <= '0;
      instr_cnt <= '0;
    end else begin
      state_q  <= next_state;
      wait_cnt <= stay_wait ? (wait_cnt + WAIT_W'(1)) : '0;
      if (instr_done) begin
        instr_cnt <= instr_cnt + CNT_W'(1);
      end
    end
  end

endmodule
